// File: rtl/chorus_mixer.sv
// Stereo wet/dry mixer with a 3-stage pipeline (capture, multiply, sum/round/scale) and a per-sample mix ramp.
// Optional build macro CHORUS_MIXER_SATURATE_EN clamps the scaled output instead of wrapping it.
module chorus_mixer #(
  parameter int DATA_WIDTH = 16,
  parameter int MIX_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] dry_left_in,
  input  logic signed [DATA_WIDTH-1:0] dry_right_in,
  input  logic signed [DATA_WIDTH-1:0] wet_left_in,
  input  logic signed [DATA_WIDTH-1:0] wet_right_in,
  input  logic        [MIX_WIDTH-1:0]  mix_target,
  input  logic        [1:0]            out_gain,
  input  logic                         bypass,
  output logic signed [DATA_WIDTH-1:0] audio_left_out,
  output logic signed [DATA_WIDTH-1:0] audio_right_out,
  output logic                         out_valid,
  output logic        [MIX_WIDTH-1:0]  mix_current,
  output logic                         ramp_busy,
  output logic        [1:0]            ramp_state
);
  // Handshake: sample_valid is a one-cycle push with no back-pressure; every
  // pulse yields exactly one out_valid pulse three cycles later unless reset intervenes.

  localparam int SW = DATA_WIDTH + MIX_WIDTH + 2;
  localparam logic signed [SW-1:0] ROUND   = SW'(1) << (MIX_WIDTH - 1);
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {HOLD = 2'd0, RAMP_UP = 2'd1, RAMP_DOWN = 2'd2} ramp_t;
  ramp_t state;

  logic                         s1_valid, s1_bypass;
  logic signed [DATA_WIDTH-1:0] s1_dry_l, s1_dry_r, s1_wet_l, s1_wet_r;
  logic        [MIX_WIDTH-1:0]  s1_mix;
  logic        [1:0]            s1_gain;

  logic                         s2_valid, s2_bypass;
  logic signed [SW-1:0]         s2_pd_l, s2_pd_r, s2_pw_l, s2_pw_r;
  logic signed [DATA_WIDTH-1:0] s2_dry_l, s2_dry_r;
  logic        [1:0]            s2_gain;

  logic        [MIX_WIDTH:0]    dry_w;
  logic signed [SW-1:0]         dry_w_ext, wet_w_ext;
  logic signed [DATA_WIDTH-1:0] res_l, res_r;

  function automatic logic signed [SW-1:0] sx(input logic signed [DATA_WIDTH-1:0] v);
    return {{(SW-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] finish_ch(
    input logic signed [SW-1:0]         pd,
    input logic signed [SW-1:0]         pw,
    input logic signed [DATA_WIDTH-1:0] dry,
    input logic                         byp,
    input logic        [1:0]            gain
  );
    logic signed [SW-1:0] sum, pre, scaled;
    sum    = pd + pw + ROUND;
    pre    = byp ? sx(dry) : (sum >>> MIX_WIDTH);
    scaled = pre <<< gain;
`ifdef CHORUS_MIXER_SATURATE_EN
    if (scaled > SAT_MAX)      scaled = SAT_MAX;
    else if (scaled < SAT_MIN) scaled = SAT_MIN;
`endif
    return scaled[DATA_WIDTH-1:0];
  endfunction

  // Weights are zero-extended so the unsigned 2^MIX_WIDTH - m multiplies as a positive value.
  always_comb begin
    dry_w     = {1'b1, {MIX_WIDTH{1'b0}}} - {1'b0, s1_mix};
    dry_w_ext = {{(SW-MIX_WIDTH-1){1'b0}}, dry_w};
    wet_w_ext = {{(SW-MIX_WIDTH){1'b0}}, s1_mix};
    res_l     = finish_ch(s2_pd_l, s2_pw_l, s2_dry_l, s2_bypass, s2_gain);
    res_r     = finish_ch(s2_pd_r, s2_pw_r, s2_dry_r, s2_bypass, s2_gain);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid        <= 1'b0;
      s2_valid        <= 1'b0;
      out_valid       <= 1'b0;
      audio_left_out  <= '0;
      audio_right_out <= '0;
      s1_bypass <= 1'b0;  s1_gain <= '0;  s1_mix <= '0;
      s1_dry_l  <= '0;    s1_dry_r <= '0; s1_wet_l <= '0; s1_wet_r <= '0;
      s2_bypass <= 1'b0;  s2_gain <= '0;
      s2_pd_l   <= '0;    s2_pd_r <= '0;  s2_pw_l <= '0;  s2_pw_r <= '0;
      s2_dry_l  <= '0;    s2_dry_r <= '0;
    end else begin
      s1_valid <= sample_valid;
      if (sample_valid) begin
        s1_dry_l  <= dry_left_in;
        s1_dry_r  <= dry_right_in;
        s1_wet_l  <= wet_left_in;
        s1_wet_r  <= wet_right_in;
        s1_mix    <= mix_current;
        s1_bypass <= bypass;
        s1_gain   <= out_gain;
      end
      s2_valid  <= s1_valid;
      s2_pd_l   <= sx(s1_dry_l) * dry_w_ext;
      s2_pd_r   <= sx(s1_dry_r) * dry_w_ext;
      s2_pw_l   <= sx(s1_wet_l) * wet_w_ext;
      s2_pw_r   <= sx(s1_wet_r) * wet_w_ext;
      s2_dry_l  <= s1_dry_l;
      s2_dry_r  <= s1_dry_r;
      s2_bypass <= s1_bypass;
      s2_gain   <= s1_gain;
      out_valid <= s2_valid;
      if (s2_valid) begin
        audio_left_out  <= res_l;
        audio_right_out <= res_r;
      end
    end
  end

  // Direction is chosen and the step taken on the same pulse, after capture latched the old mix.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= HOLD;
      mix_current <= '0;
    end else if (sample_valid) begin
      if (mix_target > mix_current) begin
        state       <= RAMP_UP;
        mix_current <= mix_current + 1'b1;
      end else if (mix_target < mix_current) begin
        state       <= RAMP_DOWN;
        mix_current <= mix_current - 1'b1;
      end else begin
        state       <= HOLD;
      end
    end
  end

  assign ramp_busy  = (mix_current != mix_target);
  assign ramp_state = state;

endmodule

// File: tb/tb_chorus_mixer.sv
// Directed plus randomized bench for chorus_mixer against a sample-level arithmetic model.
module tb_chorus_mixer;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 sample_valid = 1'b0;
  logic signed [DW-1:0] dry_left_in = '0, dry_right_in = '0, wet_left_in = '0, wet_right_in = '0;
  logic        [7:0]    mix_target = '0;
  logic        [1:0]    out_gain = '0;
  logic                 bypass = 1'b0;
  logic signed [DW-1:0] audio_left_out, audio_right_out;
  logic                 out_valid, ramp_busy;
  logic        [7:0]    mix_current;
  logic        [1:0]    ramp_state;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int model_mix = 0;
  logic [63:0] exp_q[$];

  chorus_mixer dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .dry_left_in(dry_left_in), .dry_right_in(dry_right_in),
    .wet_left_in(wet_left_in), .wet_right_in(wet_right_in),
    .mix_target(mix_target), .out_gain(out_gain), .bypass(bypass),
    .audio_left_out(audio_left_out), .audio_right_out(audio_right_out),
    .out_valid(out_valid), .mix_current(mix_current), .ramp_busy(ramp_busy),
    .ramp_state(ramp_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // Reference: weighted sum in 256ths, floor after adding a half, then gain and range handling.
  function automatic logic signed [DW-1:0] model(input int dry, input int wet, input int m,
                                                 input int gain, input bit byp);
    longint s, r;
    if (byp) r = dry;
    else begin
      s = longint'(dry) * (256 - m) + longint'(wet) * m;
      r = (s + 128) >>> 8;
    end
    r = r * (longint'(1) << gain);
`ifdef CHORUS_MIXER_SATURATE_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[DW-1:0];
  endfunction

  task automatic tick();
    bit sv_s, rst_s;
    int tgt;
    logic [63:0] e;
    bit due;
    sv_s  = sample_valid;
    rst_s = rst_n;
    tgt   = int'(mix_target);
    @(posedge clk);
    cycle++;
    if (!rst_s) begin
      model_mix = 0;
      exp_q.delete();
    end else if (sv_s) begin
      if (tgt > model_mix) model_mix++;
      else if (tgt < model_mix) model_mix--;
    end
    #1;
    chk("mix_current", mix_current, model_mix);
    chk("ramp_busy", ramp_busy, (model_mix != int'(mix_target)));
    due = (exp_q.size() > 0) && (int'(exp_q[0][63:32]) == cycle);
    chk("out_valid", out_valid, due);
    if (due) begin
      e = exp_q.pop_front();
      chk("left", audio_left_out, $signed(e[31:16]));
      chk("right", audio_right_out, $signed(e[15:0]));
    end
    if (!rst_s) begin
      chk("rst_left", audio_left_out, 0);
      chk("rst_right", audio_right_out, 0);
    end
  endtask

  task automatic send(input int dl, input int dr, input int wl, input int wr);
    logic signed [DW-1:0] el, er;
    dry_left_in  = DW'(dl);
    dry_right_in = DW'(dr);
    wet_left_in  = DW'(wl);
    wet_right_in = DW'(wr);
    sample_valid = 1'b1;
    el = model(int'(dry_left_in), int'(wet_left_in), model_mix, int'(out_gain), bypass);
    er = model(int'(dry_right_in), int'(wet_right_in), model_mix, int'(out_gain), bypass);
    exp_q.push_back({32'(cycle + 3), el, er});
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(int'($signed(16'($urandom_range(0, 65535)))), int'($signed(16'($urandom_range(0, 65535)))),
         int'($signed(16'($urandom_range(0, 65535)))), int'($signed(16'($urandom_range(0, 65535)))));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    idle(3);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_mix", mix_current, 0);
    rst_n = 1'b1;

    // Single sample, all dry, first pulse after reset
    mix_target = 8'd0; out_gain = 2'd0; bypass = 1'b0;
    send(1000, 1000, -1000, -1000);
    idle(5);

    // Ramp to half mix with back-to-back pulses, then a known-value sample
    mix_target = 8'd128;
    for (int i = 0; i < 128; i++) send_rand();
    send(1000, 1000, 3000, 3000);
    chk("half_mix_busy", ramp_busy, 0);
    idle(4);

    // Short ramp 0 -> 4 with pulses every cycle
    do_reset();
    mix_target = 8'd4;
    for (int i = 0; i < 6; i++) send(2560, -2560, 12800, -12800);
    chk("ramp4_mix", mix_current, 4);
    idle(4);

    // Gain 3 range handling on bypass
    bypass = 1'b1; out_gain = 2'd3;
    send(20000, -20000, 5, 5);
    send(-20000, 20000, 5, 5);
    send(4000, -4096, 0, 0);
    idle(4);
    bypass = 1'b0;
    for (int g = 0; g < 4; g++) begin
      out_gain = 2'(g);
      send(32767, -32768, -32768, 32767);
    end
    idle(4);

    // Reset one cycle after a sample discards it
    out_gain = 2'd0;
    send(1234, 1234, 1234, 1234);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle(5);
    chk("flush_mix", mix_current, 0);

    // Mid-ramp reversal 10 -> 20 -> 5
    mix_target = 8'd10;
    for (int i = 0; i < 10; i++) send_rand();
    mix_target = 8'd20;
    for (int i = 0; i < 3; i++) send_rand();
    chk("reversal_peak", mix_current, 13);
    mix_target = 8'd5;
    for (int i = 0; i < 10; i++) send_rand();
    chk("reversal_end", mix_current, 5);
    idle(4);

    // Ramp to the top edge and stay there without wrapping
    mix_target = 8'd255;
    for (int i = 0; i < 252; i++) send(0, 0, -32768, 32767);
    chk("top_mix", mix_current, 255);
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) mix_target = 8'($urandom_range(0, 255));
      out_gain = 2'($urandom_range(0, 3));
      bypass   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) != 0) send_rand();
      else tick();
    end
    idle(6);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
